extend: RTL and testbench

- Immediate generator for the RV32I decode stage.
- Selects the immediate field of a 32-bit instruction by ImmSrc, reassembles the scattered bits and sign-extends (or zero-fills) to 32 bits.
- Primary output ImmExt is purely combinational and drives the ALU B-mux and the branch/jump target adder.
- A registered copy (ImmExtQ) and an illegal-select flag serve a pipelined decode/execute boundary.

---
 rtl/extend.sv | 93 +++++++++
 tb/tb_extend.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/extend.sv
// rtl/extend.sv - RV32I immediate generator with registered copy
//
// Purpose: selects the immediate field of a 32-bit instruction by imm_src,
// reassembles the scattered bits and sign-extends (or zero-fills) to 32 bits.
// ImmExt/ImmErr are purely combinational. ImmExtQ/ImmErrQ register them
// for the decode/execute boundary.
//
// Optional feature macro: EXTEND_ZICSR_EN
//   defined   -> ImmSrc 101 selects CSR zimm, {27'b0, Instr[19:15]}
//   undefined -> ImmSrc 101 is unsupported (ImmExt = 0, ImmErr = 1)
//
// Ports:
//   clk      in   1   rising-edge clock, registered outputs only
//   reset    in   1   asynchronous active-high reset of registered outputs
//   en       in   1   load enable for ImmExtQ/ImmErrQ (0 = hold / stall)
//   Instr    in  32   instruction word
//   ImmSrc   in   3   immediate format select
//   ImmExt   out 32   combinational extended immediate
//   ImmErr   out  1   combinational unsupported-select flag
//   ImmExtQ  out 32   registered ImmExt
//   ImmErrQ  out  1   registered ImmErr

module extend #(
  parameter int XLEN = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [31:0] Instr,
  input  logic [2:0]  ImmSrc,
  output logic [31:0] ImmExt,
  output logic        ImmErr,
  output logic [31:0] ImmExtQ,
  output logic        ImmErrQ
);

  generate
    if (XLEN != 32) begin : g_xlen_check
      $error("extend: only XLEN = 32 is supported");
    end
  endgenerate

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;
  localparam logic [2:0] IMM_Z = 3'b101;

  // Opcode bits never fall inside any immediate field.
  logic unused_opcode;
  assign unused_opcode = ^Instr[6:0];

  // Sign bit is always Instr[31] for every signed format.
  logic sign;
  assign sign = Instr[31];

  always_comb begin
    ImmExt = 32'h0;
    ImmErr = 1'b0;
    case (ImmSrc)
      IMM_I: ImmExt = {{20{sign}}, Instr[31:20]};
      IMM_S: ImmExt = {{20{sign}}, Instr[31:25], Instr[11:7]};
      IMM_B: ImmExt = {{20{sign}}, Instr[7], Instr[30:25], Instr[11:8], 1'b0};
      IMM_J: ImmExt = {{12{sign}}, Instr[19:12], Instr[20], Instr[30:21], 1'b0};
      IMM_U: ImmExt = {Instr[31:12], 12'b0};
`ifdef EXTEND_ZICSR_EN
      IMM_Z: ImmExt = {27'b0, Instr[19:15]};
`else
      IMM_Z: begin
        ImmExt = 32'h0;
        ImmErr = 1'b1;
      end
`endif
      default: begin
        ImmExt = 32'h0;
        ImmErr = 1'b1;
      end
    endcase
  end

  // Pipeline register; reset wins over en, en=0 holds for stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ImmExtQ <= 32'h0;
      ImmErrQ <= 1'b0;
    end else if (en) begin
      ImmExtQ <= ImmExt;
      ImmErrQ <= ImmErr;
    end
  end

endmodule

// File: tb/tb_extend.sv
// tb/tb_extend.sv - directed table-driven bench for extend

module tb_extend;

  logic        clk;
  logic        reset;
  logic        en;
  logic [31:0] Instr;
  logic [2:0]  ImmSrc;
  logic [31:0] ImmExt;
  logic        ImmErr;
  logic [31:0] ImmExtQ;
  logic        ImmErrQ;

  int checks;
  int errors;

  extend #(.XLEN(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .Instr   (Instr),
    .ImmSrc  (ImmSrc),
    .ImmExt  (ImmExt),
    .ImmErr  (ImmErr),
    .ImmExtQ (ImmExtQ),
    .ImmErrQ (ImmErrQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  src;
    logic [31:0] instr;
    logic [31:0] exp_ext;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic add(input string n, input logic [2:0] s, input logic [31:0] i,
                     input logic [31:0] e, input logic r);
    vec_t v;
    v.name = n; v.src = s; v.instr = i; v.exp_ext = e; v.exp_err = r;
    vecs.push_back(v);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    en     = 1'b0;
    Instr  = 32'h0;
    ImmSrc = 3'b000;

    add("i_neg",      3'b000, 32'hFFC4A303, 32'hFFFFFFFC, 1'b0);
    add("s_pos",      3'b001, 32'h0064A423, 32'h00000008, 1'b0);
    add("s_neg",      3'b001, 32'hFE112E23, 32'hFFFFFFFC, 1'b0);
    add("b_neg",      3'b010, 32'hFE420AE3, 32'hFFFFFFF4, 1'b0);
    add("j_pos",      3'b011, 32'h0080006F, 32'h00000008, 1'b0);
    add("j_neg",      3'b011, 32'hFFDFF06F, 32'hFFFFFFFC, 1'b0);
    add("u_hi",       3'b100, 32'hF0F0F037, 32'hF0F0F000, 1'b0);
    add("u_lowfill",  3'b100, 32'h00001FFF, 32'h00001000, 1'b0);
    add("i_max",      3'b000, 32'h7FF00013, 32'h000007FF, 1'b0);
    add("i_min",      3'b000, 32'h80000013, 32'hFFFFF800, 1'b0);
    add("i_opcode",   3'b000, 32'h0000007F, 32'h00000000, 1'b0);
    add("i_one",      3'b000, 32'h00100000, 32'h00000001, 1'b0);
    add("ill_111",    3'b111, 32'hFFFFFFFF, 32'h00000000, 1'b1);
    add("ill_110",    3'b110, 32'h12345678, 32'h00000000, 1'b1);
`ifdef EXTEND_ZICSR_EN
    add("zimm_101",   3'b101, 32'h000F8073, 32'h0000001F, 1'b0);
`else
    add("ill_101",    3'b101, 32'h000F8073, 32'h00000000, 1'b1);
`endif

    // Reset state of the register while reset is held.
    #2;
    check("rst_extq", ImmExtQ, 32'h0);
    check("rst_errq", {31'b0, ImmErrQ}, 32'h0);

    // Combinational table.
    for (int k = 0; k < vecs.size(); k++) begin
      ImmSrc = vecs[k].src;
      Instr  = vecs[k].instr;
      #1;
      check({vecs[k].name, "_ext"}, ImmExt, vecs[k].exp_ext);
      check({vecs[k].name, "_err"}, {31'b0, ImmErr}, {31'b0, vecs[k].exp_err});
    end

    // Reset has priority over en across a rising edge.
    @(negedge clk);
    en = 1'b1; ImmSrc = 3'b000; Instr = 32'hFFC4A303;
    @(negedge clk);
    check("rst_prio_extq", ImmExtQ, 32'h0);

    // Release mid-cycle; first load at the next rising edge.
    #2 reset = 1'b0;
    #1 check("release_no_load", ImmExtQ, 32'h0);
    @(negedge clk);
    check("load_i_extq", ImmExtQ, 32'hFFFFFFFC);
    check("load_i_errq", {31'b0, ImmErrQ}, 32'h0);

    // Stall: registered copy holds, combinational output follows.
    en = 1'b0; Instr = 32'h7FF00013;
    @(negedge clk);
    check("hold_extq", ImmExtQ, 32'hFFFFFFFC);
    check("hold_comb", ImmExt, 32'h000007FF);
    @(negedge clk);
    check("hold_extq2", ImmExtQ, 32'hFFFFFFFC);

    // Load an illegal select to set ErrQ.
    en = 1'b1; ImmSrc = 3'b110; Instr = 32'hFFFFFFFF;
    @(negedge clk);
    check("ill_extq", ImmExtQ, 32'h0);
    check("ill_errq", {31'b0, ImmErrQ}, 32'h1);

    // Load a nonzero value, then assert reset asynchronously mid-cycle.
    ImmSrc = 3'b100; Instr = 32'hF0F0F037;
    @(negedge clk);
    check("u_extq", ImmExtQ, 32'hF0F0F000);
    check("u_errq", {31'b0, ImmErrQ}, 32'h0);
    ImmSrc = 3'b111;
    @(negedge clk);
    check("pre_rst_errq", {31'b0, ImmErrQ}, 32'h1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_extq", ImmExtQ, 32'h0);
    check("async_rst_errq", {31'b0, ImmErrQ}, 32'h0);
    @(negedge clk);
    check("rst_held_errq", {31'b0, ImmErrQ}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
